mux32_port_arbiter: RTL
=======================

// Module: mux32_port_arbiter
// PURPOSE
//  Shares one 32-bit write path between two requesters (A, B) with valid/ready handshakes.
//  Bounded-burst round-robin arbitration; selected word passes through a mux32bit_2_1 instance
//  (A = a_data, B = b_data, X = sel) into a single registered output stage.
//  Sits in front of a shared sink (register-file write port, memory write bus) in the datapath.
// PARAMETERS
//  MAX_BURST  4  consecutive transfers an owner may make while the other side waits (>=1)
//  FIRST_SRC  0  requester favoured by the first tie after reset (0=A, 1=B)
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  reset      in   1   synchronous reset, active-high
//  a_valid    in   1   requester A offers a_data
//  a_data     in   32  requester A word
//  a_ready    out  1   A's word accepted this cycle (a_valid & a_ready = transfer)
//  b_valid    in   1   requester B offers b_data
//  b_data     in   32  requester B word
//  b_ready    out  1   B's word accepted this cycle
//  out_valid  out  1   out_data holds an undelivered word
//  out_data   out  32  registered selected word
//  out_ready  in   1   sink accepts out_data (out_valid & out_ready = delivery)
//  out_src    out  1   source of out_data (0=A, 1=B)
//  sel        out  1   current mux select (0=A, 1=B), combinational, for debug/trace
// BEHAVIOUR
//  State: IDLE / OWN_A / OWN_B; burst counter cnt (saturates at MAX_BURST); last (last served).
//  Reset (sync, on reset=1 at clk edge): out_valid=0, out_data=0, out_src=0, state=IDLE, cnt=0,
//   last=~FIRST_SRC. Reset wins over any simultaneous transfer; in-flight word is dropped.
//  can_load = !out_valid | out_ready (single output register, no skid buffer).
//  Winner w (combinational, every cycle):
//   IDLE : both valid -> ~last; one valid -> that one; none -> no winner.
//   OWN_A: a_valid & (cnt<MAX_BURST | !b_valid) -> A; else b_valid -> B; else none.
//   OWN_B: symmetric with A/B swapped.
//  sel = (w==B); sel=0 when no winner. a_ready = can_load & w==A; b_ready = can_load & w==B.
//  Never both readies high in one cycle; ready never asserted for a requester with valid low.
//  On transfer (can_load & winner): out_data<=mux output, out_valid<=1, out_src<=w, last<=w,
//   state<=OWN_w, cnt<= (state==OWN_w) ? min(cnt+1, MAX_BURST) : 1.
//  can_load & no winner: out_valid<= out_valid & !out_ready, state<=IDLE, cnt<=0.
//  !can_load (stall): state, cnt, last, out_* hold; requesters must keep valid/data stable.
//  Latency: accepted word visible on out_data the next cycle; 1 word/cycle with out_ready=1.
//  Burst limit: owner alone keeps the grant indefinitely (cnt saturates); when other side is
//   valid, it gets the grant after exactly MAX_BURST owner transfers, or at once if owner drops valid.
//  MAX_BURST=1 degenerates to strict alternation under continuous contention.
//  Delivery and new acceptance in the same cycle are allowed (out_valid stays 1, data replaced).
// TESTING
//  1 Reset: drive reset=1 for 1 cycle with out_valid=1 -> next cycle out_valid=0, out_data=0,
//    sel=0; first tie afterwards (a/b valid together) served A (FIRST_SRC=0).
//  2 Single A: a_valid=1, a_data=32'hDEADBEEF, out_ready=1 -> a_ready=1 same cycle; next cycle
//    out_valid=1, out_data=32'hDEADBEEF, out_src=0; b_ready stays 0.
//  3 Contention, MAX_BURST=4, a/b valid constant, out_ready=1 -> out_src sequence
//    A,A,A,A,B,B,B,B,A,... one word per cycle, no gaps.
//  4 Backpressure: out_valid=1, out_ready=0 for 5 cycles -> a_ready=b_ready=0, out_data/out_src
//    stable; out_ready=1 -> delivery and next acceptance in same cycle.
//  5 Owner drop: OWN_B with cnt=2, b_valid falls, a_valid=1 -> a_ready=1 that cycle, state OWN_A,
//    cnt=1; then both drop -> IDLE, cnt=0, out_valid clears after delivery.
//  6 Solo burst: only a_valid for 10 cycles -> 10 A words, cnt holds at 4; b_valid rises ->
//    B granted on the very next cycle.

Source files
------------

// File: rtl/mux32_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux32_port_arbiter (with helper mux32bit_2_1)
//  Description : Two-requester valid/ready arbiter sharing one 32-bit write
//                path. Bounded-burst round-robin choice of A or B, the chosen
//                word passes through a 2:1 word mux into a single registered
//                output stage with its own valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  mux32bit_2_1 : plain 32-bit 2:1 multiplexer, Y = X ? B : A
// ----------------------------------------------------------------------------
module mux32bit_2_1 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        X,
    output logic [31:0] Y
);

    // Pure select, no state
    always_comb begin
        Y = X ? B : A;
    end

endmodule

// ----------------------------------------------------------------------------
//  mux32_port_arbiter : top level
// ----------------------------------------------------------------------------
module mux32_port_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int FIRST_SRC = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        out_src,
    output logic        sel
);

    // Counter only needs to reach MAX_BURST, where it saturates
    localparam int            CW        = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] C_MAX     = CW'(MAX_BURST);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic          C_FIRST_B = (FIRST_SRC != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_A = 2'd1,
        S_OWN_B = 2'd2
    } state_t;

    // Registered state
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic          r_out_valid;
    logic [31:0]   r_out_data;
    logic          r_out_src;

    // Next-state values
    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_last_nxt;
    logic          w_out_valid_nxt;
    logic [31:0]   w_out_data_nxt;
    logic          w_out_src_nxt;

    // Arbitration
    logic          w_can_load;
    logic          w_has_win;
    logic          w_win;        // 0 = A, 1 = B; only meaningful with w_has_win
    logic          w_under_max;
    logic [31:0]   w_mux_y;
    state_t        w_win_state;

    // The single output register may be refilled when empty or being drained
    always_comb begin
        w_can_load  = !r_out_valid || out_ready;
        w_under_max = (r_cnt < C_MAX);
    end

    // Winner selection: round-robin on ties from idle, bounded burst for owner
    always_comb begin
        w_has_win = 1'b0;
        w_win     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (a_valid && b_valid) begin
                    w_has_win = 1'b1;
                    w_win     = ~r_last;
                end else if (a_valid) begin
                    w_has_win = 1'b1;
                    w_win     = 1'b0;
                end else if (b_valid) begin
                    w_has_win = 1'b1;
                    w_win     = 1'b1;
                end
            end
            S_OWN_A: begin
                if (a_valid && (w_under_max || !b_valid)) begin
                    w_has_win = 1'b1;
                    w_win     = 1'b0;
                end else if (b_valid) begin
                    w_has_win = 1'b1;
                    w_win     = 1'b1;
                end
            end
            S_OWN_B: begin
                if (b_valid && (w_under_max || !a_valid)) begin
                    w_has_win = 1'b1;
                    w_win     = 1'b1;
                end else if (a_valid) begin
                    w_has_win = 1'b1;
                    w_win     = 1'b0;
                end
            end
            default: begin
                w_has_win = 1'b0;
                w_win     = 1'b0;
            end
        endcase
    end

    // Mux select and handshake outputs derived from the winner
    always_comb begin
        sel         = w_has_win && w_win;
        a_ready     = w_can_load && w_has_win && !w_win;
        b_ready     = w_can_load && w_has_win &&  w_win;
        w_win_state = w_win ? S_OWN_B : S_OWN_A;
    end

    mux32bit_2_1 u_mux (
        .A (a_data),
        .B (b_data),
        .X (sel),
        .Y (w_mux_y)
    );

    // Next-state: load on transfer, drain/idle with no winner, hold on stall
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_src_nxt   = r_out_src;
        if (w_can_load) begin
            if (w_has_win) begin
                w_out_data_nxt  = w_mux_y;
                w_out_valid_nxt = 1'b1;
                w_out_src_nxt   = w_win;
                w_last_nxt      = w_win;
                w_state_nxt     = w_win_state;
                if (r_state == w_win_state) begin
                    w_cnt_nxt = (r_cnt == C_MAX) ? C_MAX : (r_cnt + C_ONE);
                end else begin
                    w_cnt_nxt = C_ONE;
                end
            end else begin
                w_out_valid_nxt = r_out_valid && !out_ready;
                w_state_nxt     = S_IDLE;
                w_cnt_nxt       = '0;
            end
        end
    end

    // State register; reset drops any in-flight word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= ~C_FIRST_B;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_src   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_src   <= w_out_src_nxt;
        end
    end

    // Drive registered outputs
    always_comb begin
        out_valid = r_out_valid;
        out_data  = r_out_data;
        out_src   = r_out_src;
    end

endmodule
`default_nettype wire
